// File: rtl/unstripe_cfg_if.sv
// Bundles the config handshake, the data qualifiers and the status outputs
// exchanged between the unstripe sequencing controller and its neighbours.
interface unstripe_cfg_if;
  logic        cfg_req;
  logic [5:0]  cfg_pipewidth;
  logic [4:0]  cfg_lanes;
  logic        cfg_ack;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  pipewidth_o;
  logic [4:0]  lanesnumber_o;
  logic        out_valid;
  logic [6:0]  out_bytes;
  logic [15:0] word_cnt;
  logic        drop_err;
  logic        busy;

  modport slave (
    input  cfg_req, cfg_pipewidth, cfg_lanes, in_valid,
    output cfg_ack, cfg_err, in_ready, pipewidth_o, lanesnumber_o,
           out_valid, out_bytes, word_cnt, drop_err, busy
  );

  modport master (
    output cfg_req, cfg_pipewidth, cfg_lanes, in_valid,
    input  cfg_ack, cfg_err, in_ready, pipewidth_o, lanesnumber_o,
           out_valid, out_bytes, word_cnt, drop_err, busy
  );
endinterface

// File: rtl/unstripe_cfg_ctrl.sv
// Sequences PIPEWIDTH/LANESNUMBER changes for the receive unstriper (request,
// drain, apply or reject) and qualifies its one-cycle-registered output.
module unstripe_cfg_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  unstripe_cfg_if.slave  bus
);
  localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES == 32'd0) ? 4'd1 : 4'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    ST_UNCFG  = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_APPLY  = 3'd3,
    ST_REJECT = 3'd4
  } state_t;

  function automatic logic cfg_legal(input logic [5:0] pw, input logic [4:0] ln);
    logic pw_ok;
    logic ln_ok;
    case (pw)
      6'd8, 6'd16, 6'd32: pw_ok = 1'b1;
      default:            pw_ok = 1'b0;
    endcase
    case (ln)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: ln_ok = 1'b1;
      default:                       ln_ok = 1'b0;
    endcase
    return pw_ok & ln_ok;
  endfunction

  // Only legal configs are ever applied, so the product always fits 1..64.
  function automatic logic [6:0] word_bytes(input logic [2:0] pw_div8, input logic [4:0] ln);
    return 7'({4'b0000, pw_div8} * {2'b00, ln});
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  drain_cnt_r;
  logic        cfg_valid_r;
  logic [5:0]  pipewidth_r;
  logic [4:0]  lanes_r;
  logic        in_ready_r, busy_r, cfg_ack_r, cfg_err_r;
  logic        out_valid_r;
  logic [6:0]  out_bytes_r;
  logic [15:0] word_cnt_r;
  logic        drop_err_r;
  logic        accepted_s;

  assign accepted_s = bus.in_valid & in_ready_r;

  // Next-state decode; requests are sampled only in UNCFG and ACTIVE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_UNCFG, ST_ACTIVE: begin
        if (bus.cfg_req) begin
          state_s = cfg_legal(bus.cfg_pipewidth, bus.cfg_lanes) ? ST_DRAIN : ST_REJECT;
        end else begin
          state_s = state_r;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r <= 4'd1) begin
          state_s = ST_APPLY;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_APPLY:  state_s = ST_ACTIVE;
      ST_REJECT: state_s = cfg_valid_r ? ST_ACTIVE : ST_UNCFG;
      default:   state_s = ST_UNCFG;
    endcase
  end

  // State register plus state-decoded flags registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_UNCFG;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      cfg_ack_r  <= 1'b0;
      cfg_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == ST_ACTIVE);
      busy_r     <= (state_s == ST_DRAIN) || (state_s == ST_APPLY) || (state_s == ST_REJECT);
      cfg_ack_r  <= (state_s == ST_APPLY) || (state_s == ST_REJECT);
      cfg_err_r  <= (state_s == ST_REJECT);
    end
  end

  // Drain counter: held at the load value outside DRAIN, so it is loaded on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt_r <= DRAIN_LOAD;
    end else if (state_r != ST_DRAIN) begin
      drain_cnt_r <= DRAIN_LOAD;
    end else begin
      drain_cnt_r <= drain_cnt_r - 4'd1;
    end
  end

  // Unstriper configuration; changes only in APPLY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipewidth_r <= 6'd0;
      lanes_r     <= 5'd0;
      cfg_valid_r <= 1'b0;
    end else if (state_r == ST_APPLY) begin
      pipewidth_r <= bus.cfg_pipewidth;
      lanes_r     <= bus.cfg_lanes;
      cfg_valid_r <= 1'b1;
    end else begin
      pipewidth_r <= pipewidth_r;
      lanes_r     <= lanes_r;
      cfg_valid_r <= cfg_valid_r;
    end
  end

  // Output qualifier aligned with the unstriper register, word count and drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_bytes_r <= 7'd0;
      word_cnt_r  <= 16'd0;
      drop_err_r  <= 1'b0;
    end else begin
      out_valid_r <= accepted_s;
      out_bytes_r <= accepted_s ? word_bytes(pipewidth_r[5:3], lanes_r) : 7'd0;
      if (state_r == ST_APPLY) begin
        word_cnt_r <= 16'd0;
      end else if (out_valid_r && (word_cnt_r != 16'hFFFF)) begin
        word_cnt_r <= word_cnt_r + 16'd1;
      end else begin
        word_cnt_r <= word_cnt_r;
      end
      drop_err_r <= drop_err_r | (bus.in_valid & ~in_ready_r);
    end
  end

  assign bus.in_ready      = in_ready_r;
  assign bus.busy          = busy_r;
  assign bus.cfg_ack       = cfg_ack_r;
  assign bus.cfg_err       = cfg_err_r;
  assign bus.pipewidth_o   = pipewidth_r;
  assign bus.lanesnumber_o = lanes_r;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_bytes     = out_bytes_r;
  assign bus.word_cnt      = word_cnt_r;
  assign bus.drop_err      = drop_err_r;
endmodule

// File: tb/tb_unstripe_cfg_ctrl.sv
// Self-checking bench for unstripe_cfg_ctrl: a timeline-based reference model
// checks every cycle, plus a config table and hand-written corner sequences.
module tb_unstripe_cfg_ctrl;
  localparam int D    = 3;
  localparam int DEFF = (D == 0) ? 1 : D;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  unstripe_cfg_if bus();
  unstripe_cfg_ctrl #(.DRAIN_CYCLES(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { int pw; int ln; bit err; int bytes; } vec_t;
  vec_t tbl[10];
  int   pws[6] = '{8, 16, 32, 24, 0, 16};
  int   lns[7] = '{1, 2, 4, 8, 16, 3, 0};

  // Reference model: a pending request is a window of cycles ending at its ack cycle.
  bit m_seq, m_legal, m_cfgv, m_drop, m_ov;
  int m_ack_cyc, m_cyc, m_pw, m_ln, m_ob, m_wc;

  logic        last_ack, last_err, last_rdy, last_ov, last_drop, last_busy;
  logic [6:0]  last_ob;
  logic [15:0] last_wc;
  logic [5:0]  last_pw;
  logic [4:0]  last_ln;

  function automatic bit is_legal(int pw, int ln);
    return (pw == 8 || pw == 16 || pw == 32) &&
           (ln == 1 || ln == 2 || ln == 4 || ln == 8 || ln == 16);
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)", name, got, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_seq = 0; m_legal = 0; m_cfgv = 0; m_drop = 0; m_ov = 0;
    m_ack_cyc = 0; m_cyc = 0; m_pw = 0; m_ln = 0; m_ob = 0; m_wc = 0;
  endtask

  function automatic logic [39:0] out_vec();
    return {bus.in_ready, bus.busy, bus.cfg_ack, bus.cfg_err, bus.pipewidth_o,
            bus.lanesnumber_o, bus.out_valid, bus.out_bytes, bus.word_cnt, bus.drop_err};
  endfunction

  // One clock cycle: compare at negedge, advance the model, return at posedge+1.
  task automatic tick();
    logic [39:0] exp;
    bit rdy, ack, n_ov;
    int n_ob;
    @(negedge clk);
    rdy = !m_seq && m_cfgv;
    ack = m_seq && (m_cyc == m_ack_cyc);
    exp = {rdy, m_seq, ack, ack && !m_legal, 6'(m_pw), 5'(m_ln), m_ov, 7'(m_ob), 16'(m_wc), m_drop};
    check("outputs", 64'(out_vec()), 64'(exp));
    last_ack = bus.cfg_ack;  last_err = bus.cfg_err;   last_rdy = bus.in_ready;
    last_ov  = bus.out_valid; last_ob = bus.out_bytes; last_wc  = bus.word_cnt;
    last_drop = bus.drop_err; last_pw = bus.pipewidth_o; last_ln = bus.lanesnumber_o;
    last_busy = bus.busy;
    n_ov = bus.in_valid && rdy;
    n_ob = n_ov ? (m_pw / 8) * m_ln : 0;
    if (ack && m_legal) m_wc = 0;
    else if (m_ov && m_wc < 65535) m_wc++;
    if (bus.in_valid && !rdy) m_drop = 1;
    if (ack) begin
      m_seq = 0;
      if (m_legal) begin
        m_pw = int'(bus.cfg_pipewidth); m_ln = int'(bus.cfg_lanes); m_cfgv = 1;
      end
    end else if (!m_seq && bus.cfg_req) begin
      m_seq     = 1;
      m_legal   = is_legal(int'(bus.cfg_pipewidth), int'(bus.cfg_lanes));
      m_ack_cyc = m_cyc + (m_legal ? DEFF + 1 : 1);
    end
    m_ov = n_ov; m_ob = n_ob; m_cyc++;
    @(posedge clk);
    #1;
  endtask

  // Holds a request until cfg_ack; lat is ack cycle minus first sampled cycle.
  task automatic do_req(int pw, int ln, output int lat, output bit err);
    bus.cfg_pipewidth = 6'(pw); bus.cfg_lanes = 5'(ln); bus.cfg_req = 1'b1;
    lat = -1; err = 0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      tick();
      if (last_ack) begin lat = k - 1; err = last_err; end
    end
    bus.cfg_req = 1'b0;
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL req_timeout: no cfg_ack for %0d/%0d", pw, ln);
    end
  endtask

  task automatic send_word();
    bus.in_valid = 1'b1; tick();
    bus.in_valid = 1'b0; tick();
  endtask

  initial begin
    int lat;
    bit err;
    bit ack_seen;
    tbl[0] = '{8, 1, 0, 1};    tbl[1] = '{32, 16, 0, 64}; tbl[2] = '{16, 3, 1, 64};
    tbl[3] = '{16, 4, 0, 8};   tbl[4] = '{8, 2, 0, 2};    tbl[5] = '{24, 1, 1, 2};
    tbl[6] = '{32, 8, 0, 32};  tbl[7] = '{8, 0, 1, 32};   tbl[8] = '{16, 16, 0, 32};
    tbl[9] = '{0, 0, 1, 32};

    bus.cfg_req = 1'b0; bus.cfg_pipewidth = 6'd0; bus.cfg_lanes = 5'd0; bus.in_valid = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check("reset_values", 64'(out_vec()), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // UNCFG holds in_ready low; an illegal request returns to UNCFG.
    tick(); tick();
    check("uncfg_ready", 64'(last_rdy), 64'd0);
    do_req(16, 3, lat, err);
    check("uncfg_rej_lat", 64'(lat), 64'd1);
    check("uncfg_rej_err", 64'(err), 64'd1);
    tick();
    check("uncfg_after_rej_ready", 64'(last_rdy), 64'd0);
    check("uncfg_after_rej_busy", 64'(last_busy), 64'd0);

    // First legal config: ack DRAIN_CYCLES+1 after sampling, applied the cycle after.
    do_req(8, 1, lat, err);
    check("first_apply_lat", 64'(lat), 64'(DEFF + 1));
    check("first_apply_err", 64'(err), 64'd0);
    tick();
    check("first_apply_pw", 64'(last_pw), 64'd8);
    check("first_apply_ln", 64'(last_ln), 64'd1);
    check("first_apply_ready", 64'(last_rdy), 64'd1);

    // Table: each config's ack/err, latency, and byte count of a word sent after.
    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i].pw, tbl[i].ln, lat, err);
      check("tbl_err", 64'(err), 64'(tbl[i].err));
      check("tbl_lat", 64'(lat), 64'(tbl[i].err ? 1 : DEFF + 1));
      send_word();
      check("tbl_out_valid", 64'(last_ov), 64'd1);
      check("tbl_out_bytes", 64'(last_ob), 64'(tbl[i].bytes));
    end

    // 32/16 stream of five words.
    do_req(32, 16, lat, err);
    bus.in_valid = 1'b1;
    repeat (5) tick();
    bus.in_valid = 1'b0;
    tick();
    check("stream_bytes", 64'(last_ob), 64'd64);
    tick();
    check("stream_word_cnt", 64'(last_wc), 64'd5);

    // Request together with a word: the word leaves under the old config.
    do_req(16, 4, lat, err);
    bus.in_valid = 1'b1; tick();
    bus.cfg_pipewidth = 6'd8; bus.cfg_lanes = 5'd2; bus.cfg_req = 1'b1; tick();
    bus.in_valid = 1'b0; tick();
    check("switch_last_valid", 64'(last_ov), 64'd1);
    check("switch_last_bytes", 64'(last_ob), 64'd8);
    check("switch_drain_ready", 64'(last_rdy), 64'd0);
    do_req(8, 2, lat, err);
    send_word();
    check("switch_new_bytes", 64'(last_ob), 64'd2);
    check("switch_word_cnt", 64'(last_wc), 64'd0);

    // Word offered during DRAIN is dropped and flagged.
    bus.cfg_pipewidth = 6'd16; bus.cfg_lanes = 5'd4; bus.cfg_req = 1'b1; tick();
    bus.in_valid = 1'b1; tick();
    bus.in_valid = 1'b0; tick();
    check("drop_no_valid", 64'(last_ov), 64'd0);
    check("drop_flag", 64'(last_drop), 64'd1);
    do_req(16, 4, lat, err);

    // Randomised traffic and requests, checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      if (!bus.cfg_req && $urandom_range(0, 15) == 0) begin
        bus.cfg_pipewidth = 6'(pws[$urandom_range(0, 5)]);
        bus.cfg_lanes     = 5'(lns[$urandom_range(0, 6)]);
        bus.cfg_req       = 1'b1;
      end
      tick();
      if (last_ack) bus.cfg_req = 1'b0;
    end
    bus.in_valid = 1'b0; bus.cfg_req = 1'b0;
    tick(); tick(); tick();
    check("drop_sticky", 64'(last_drop), 64'd1);

    // Reset during DRAIN abandons the request without an ack.
    while (!last_rdy) tick();
    bus.cfg_pipewidth = 6'd32; bus.cfg_lanes = 5'd8; bus.cfg_req = 1'b1;
    tick(); tick();
    #2 reset = 1'b0;
    #1 check("reset_in_drain", 64'(out_vec()), 64'd0);
    bus.cfg_req = 1'b0;
    model_reset();
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    ack_seen = 0;
    repeat (10) begin tick(); ack_seen |= last_ack; end
    check("no_ack_after_reset", 64'(ack_seen), 64'd0);

    // Saturation of word_cnt.
    do_req(8, 1, lat, err);
    bus.in_valid = 1'b1;
    repeat (65540) tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    check("word_cnt_saturate", 64'(last_wc), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/unstripe_cfg_ctrl.md
# unstripe_cfg_ctrl

Sequencing controller for the receive unstriping datapath. Owns the PIPEWIDTH/LANESNUMBER configuration that drives the unstriper and changes it only when the datapath is idle. A change runs as request, drain, apply; illegal requests are rejected. Gates upstream data with a ready signal and produces a valid/byte-count qualifier aligned to the unstriper's one-cycle registered output.

## Interface
- DRAIN_CYCLES, 1: idle cycles inserted after the last accepted word before a new config is applied. Legal 1..15; 0 behaves as 1.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- cfg_req  in  1  config change request, level; fields held stable until cfg_ack
- cfg_pipewidth  in  6  requested PIPEWIDTH
- cfg_lanes  in  5  requested LANESNUMBER
- cfg_ack  out  1  one-cycle pulse, request completed (applied or rejected)
- cfg_err  out  1  one-cycle pulse with cfg_ack when the request was illegal
- in_valid  in  1  stripped word present at unstriper input this cycle
- in_ready  out  1  controller accepts stripped data this cycle
- pipewidth_o  out  6  PIPEWIDTH driven to unstriper
- lanesnumber_o  out  5  LANESNUMBER driven to unstriper
- out_valid  out  1  unstriper output word valid this cycle
- out_bytes  out  7  valid bytes in that word
- word_cnt  out  16  words output since last apply, saturating
- drop_err  out  1  sticky: in_valid seen while in_ready=0
- busy  out  1  high in DRAIN, APPLY, REJECT

## Operation
- Legal config: pipewidth in {8,16,32} and lanes in {1,2,4,8,16}. Anything else is illegal.
- Bytes per word: (pipewidth/8)*lanes, range 1..64.
- States and transitions:
  - UNCFG (reset state): in_ready=0. On cfg_req, go to DRAIN if legal, REJECT if illegal.
  - ACTIVE: in_ready=1. On cfg_req, go to DRAIN if legal, REJECT if illegal.
  - DRAIN: load counter with DRAIN_CYCLES on entry and decrement each cycle. Go to APPLY when the counter reaches 1.
  - APPLY: one cycle, then ACTIVE.
  - REJECT: one cycle, then ACTIVE if a config was ever applied, else UNCFG.
- in_ready is a pure decode of state: high only in ACTIVE.
- APPLY cycle:
  - cfg_ack=1.
  - Capture cfg_pipewidth and cfg_lanes into pipewidth_o and lanesnumber_o.
  - Clear word_cnt.
  - Set the config-valid flag.
- REJECT cycle: cfg_ack=1 and cfg_err=1. Config and word_cnt are unchanged.
- A request for the config already in effect still runs the full DRAIN/APPLY sequence.
- cfg_req is sampled only in UNCFG and ACTIVE. The requester must drop it in the cycle after cfg_ack.
- Accepted word means in_valid & in_ready.
  - out_valid is the accepted flag registered once.
  - out_bytes is the registered byte count of the config in effect when the word was accepted. It is 0 when out_valid=0.
- word_cnt increments by 1 each cycle out_valid=1 and saturates at 0xFFFF.
- drop_err sets on any cycle with in_valid=1 and in_ready=0. Only reset clears it. The dropped word produces no out_valid.
- The registered config outputs are the only source of unstriper configuration. They never change outside APPLY.

## Timing
- Reset values (asynchronous):
  - State UNCFG.
  - pipewidth_o=0, lanesnumber_o=0, so the unstriper outputs zero.
  - out_valid=0, out_bytes=0, word_cnt=0.
  - cfg_ack=0, cfg_err=0, drop_err=0, busy=0, in_ready=0.
  - Config-valid flag cleared.
- Reset mid-sequence abandons the request without cfg_ack. The requester re-issues it after reset.
- Legal request sampled at cycle t in ACTIVE:
  - A word accepted at t appears at t+1 with the old config.
  - DRAIN occupies t+1..t+DRAIN_CYCLES.
  - APPLY is at t+DRAIN_CYCLES+1, with cfg_ack.
  - New config and in_ready=1 appear at t+DRAIN_CYCLES+2.
- Illegal request sampled at t: REJECT at t+1 (cfg_ack=cfg_err=1), prior state resumes at t+2.
- Latency from accepted word to out_valid: exactly 1 cycle, matching the unstriper register.
- Simultaneous in_valid and cfg_req in ACTIVE: the word is accepted, then the change sequence starts. No word is ever output under a config it was not accepted with.

## Test plan
- Reset, then cfg 8/1 with DRAIN_CYCLES=1: req at t -> ack at t+2, pipewidth_o=8 and lanesnumber_o=1 at t+3, in_ready=1 at t+3. Before that, in_ready=0 throughout UNCFG.
- Config 32/16, stream 5 words -> each out_valid 1 cycle after acceptance, out_bytes=64, word_cnt=5.
- Stream words under 16/4, then request 8/2 while in_valid=1 -> the last word gives out_bytes=8 under the old config. Next, in_ready=0 for DRAIN and APPLY. Then out_bytes=2 under the new config, and word_cnt restarts at 0.
- Request 16/3 from ACTIVE -> cfg_ack=cfg_err=1 at t+1, config unchanged, in_ready=1 at t+2. The same request from UNCFG -> returns to UNCFG.
- Assert in_valid during DRAIN -> drop_err=1 and stays 1 through later applies. No out_valid is produced for that word.
- Assert reset during DRAIN -> all outputs take reset values immediately and no cfg_ack is ever issued. Separately, 65540 consecutive words -> word_cnt holds at 0xFFFF.
